// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM states and alignment helpers shared by the load/store unit
package mem_access_pkg;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;
  function automatic logic is_sub(input logic [1:0] size);
    return size == SZ_HALF || size == SZ_BYTE;
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return size == SZ_HALF ? lo[0] : !is_sub(size) && lo != 2'b00;
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: request/response and memory-side signals of the load/store unit
interface mem_access_if;
  logic req, we, sign_ext, mem_wr, busy, done, misalign;
  logic [1:0] size;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_rdata,
    input rdata, busy, done, misalign, mem_addr, mem_wr, mem_wdata
  );
  modport slave (
    input req, we, size, sign_ext, addr, wdata, mem_rdata,
    output rdata, busy, done, misalign, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_access_lane_merge.sv
// lane_merge: little-endian lane extract/extend for loads and lane insert for read-modify-write stores
module lane_merge
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        sign_ext,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ext,
  output logic [31:0] merged
);
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [31:0] mb, mh;
  // half lane follows lo[1] only, so odd half addresses fall back to the containing half
  always_comb begin
    byte_v = lo[1] ? (lo[0] ? word[31:24] : word[23:16]) : (lo[0] ? word[15:8] : word[7:0]);
    half_v = lo[1] ? word[31:16] : word[15:0];
    ext = size == SZ_BYTE ? {{24{sign_ext & byte_v[7]}}, byte_v} :
          size == SZ_HALF ? {{16{sign_ext & half_v[15]}}, half_v} : word;
    mb = lo == 2'd0 ? {word[31:8], wdata[7:0]} :
         lo == 2'd1 ? {word[31:16], wdata[7:0], word[7:0]} :
         lo == 2'd2 ? {word[31:24], wdata[7:0], word[15:0]} : {wdata[7:0], word[23:0]};
    mh = lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
    merged = size == SZ_BYTE ? mb : size == SZ_HALF ? mh : wdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer with sub-word read-modify-write; ALIGN_CHECK_EN enables misalignment faults
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic reset,
  mem_access_if.slave bus
);
  state_e state_q, state_d;
  logic [1:0] cnt_q, size_q;
  logic we_q, sext_q, last_rd, mis_now, accept;
  logic [31:0] addr_q, wdata_q, rword_q, rdata_q, lane_word, ext, merged;
`ifdef ALIGN_CHECK_EN
  logic mis_q;
  assign mis_now = misaligned(bus.size, bus.addr[1:0]);
  assign bus.misalign = state_q == DONE && mis_q;
`else
  assign mis_now = 1'b0;
  assign bus.misalign = 1'b0;
`endif
  assign accept = state_q == IDLE && bus.req;
  assign last_rd = cnt_q == 2'(MEM_LAT - 1);
  assign lane_word = state_q == RD ? bus.mem_rdata : rword_q;
  assign bus.mem_addr = {addr_q[31:2], 2'b00};
  assign bus.mem_wr = state_q == WR;
  assign bus.mem_wdata = merged;
  assign bus.rdata = rdata_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  lane_merge u_lane (
    .size(size_q), .lo(addr_q[1:0]), .sign_ext(sext_q), .word(lane_word),
    .wdata(wdata_q), .ext(ext), .merged(merged)
  );
  // state register and read-latency counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= state_q == RD && !last_rd ? cnt_q + 2'd1 : 2'd0;
    end
  // next state: sub-word stores read first so the untouched lanes survive the write
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.req) state_d = mis_now ? DONE : bus.we && !is_sub(bus.size) ? WR : RD;
      RD:   if (last_rd) state_d = we_q ? WR : DONE;
      WR:   state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end
  // request fields latched on accept; memory word and load result captured on the last RD edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      we_q <= 1'b0;
      sext_q <= 1'b0;
      size_q <= SZ_WORD;
      addr_q <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      rdata_q <= '0;
`ifdef ALIGN_CHECK_EN
      mis_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        we_q <= bus.we;
        sext_q <= bus.sign_ext;
        size_q <= bus.size;
        addr_q <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (state_q == RD && last_rd) rword_q <= bus.mem_rdata;
      if (state_q == RD && last_rd && !we_q) rdata_q <= ext;
`ifdef ALIGN_CHECK_EN
      mis_q <= accept && mis_now;
`endif
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for MEM_LAT=1 and MEM_LAT=3 instances of mem_access_unit
module tb_mem_access_unit;
  import mem_access_pkg::*;
  typedef struct {
    int lat;
    int nwr;
    logic [31:0] wd;
    logic [31:0] wa;
    logic [31:0] rd;
    logic mis;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic [31:0] last_rd[2];
  logic req[2], we[2], sext[2];
  logic [1:0] size[2];
  logic [31:0] addr[2], wdata[2], mrd[2];
  logic done_o[2], busy_o[2], mwr_o[2], mis_o[2];
  logic [31:0] rd_o[2], madr_o[2], mwd_o[2];
  always #5 clk = ~clk;
  mem_access_if bus1();
  mem_access_if bus3();
  mem_access_unit #(.MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  mem_access_unit #(.MEM_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));
  assign {bus1.req, bus1.we, bus1.size, bus1.sign_ext, bus1.addr, bus1.wdata, bus1.mem_rdata} =
         {req[0], we[0], size[0], sext[0], addr[0], wdata[0], mrd[0]};
  assign {bus3.req, bus3.we, bus3.size, bus3.sign_ext, bus3.addr, bus3.wdata, bus3.mem_rdata} =
         {req[1], we[1], size[1], sext[1], addr[1], wdata[1], mrd[1]};
  assign {done_o[0], busy_o[0], mwr_o[0], mis_o[0], rd_o[0], madr_o[0], mwd_o[0]} =
         {bus1.done, bus1.busy, bus1.mem_wr, bus1.misalign, bus1.rdata, bus1.mem_addr, bus1.mem_wdata};
  assign {done_o[1], busy_o[1], mwr_o[1], mis_o[1], rd_o[1], madr_o[1], mwd_o[1]} =
         {bus3.done, bus3.busy, bus3.mem_wr, bus3.misalign, bus3.rdata, bus3.mem_addr, bus3.mem_wdata};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int shamt(input logic [1:0] sz, input logic [1:0] lo);
    return sz == 2'b10 ? int'(lo) * 8 : int'(lo[1]) * 16;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz, input logic se, input logic [1:0] lo);
    logic [31:0] s;
    s = w >> shamt(sz, lo);
    if (sz == 2'b10) return {{24{se & s[7]}}, s[7:0]};
    if (sz == 2'b01) return {{16{se & s[15]}}, s[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] insert(input logic [31:0] w, input logic [31:0] wd, input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] mask;
    mask = (sz == 2'b10 ? 32'h0000_00FF : 32'h0000_FFFF) << shamt(sz, lo);
    return (w & ~mask) | ((wd << shamt(sz, lo)) & mask);
  endfunction

  function automatic exp_t model(input int d, input logic w, input logic [1:0] sz, input logic se,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw);
    exp_t e;
    int lat;
    logic sub, m;
    lat = d == 1 ? 3 : 1;
    sub = sz == 2'b01 || sz == 2'b10;
    m = 1'b0;
`ifdef ALIGN_CHECK_EN
    m = (sz == 2'b01 && a[0]) || (!sub && a[1:0] != 2'b00);
`endif
    e.mis = m;
    e.wa = {a[31:2], 2'b00};
    e.rd = last_rd[d];
    e.nwr = (w && !m) ? 1 : 0;
    e.wd = '0;
    if (m) e.lat = 1;
    else if (!w) begin
      e.lat = lat + 1;
      e.rd = extract(mw, sz, se, a[1:0]);
    end else if (!sub) begin
      e.lat = 2;
      e.wd = wd;
    end else begin
      e.lat = lat + 2;
      e.wd = insert(mw, wd, sz, a[1:0]);
    end
    last_rd[d] = e.rd;
    return e;
  endfunction

  task automatic drive(input int d, input logic w, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw);
    req[d] = 1'b1;
    we[d] = w;
    size[d] = sz;
    sext[d] = se;
    addr[d] = a;
    wdata[d] = wd;
    mrd[d] = mw;
  endtask

  task automatic start(input int d, input logic w, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw);
    sb.push_back(model(d, w, sz, se, a, wd, mw));
    drive(d, w, sz, se, a, wd, mw);
  endtask

  task automatic wait_done(input int d, input string tag);
    exp_t e;
    int cyc, nwr;
    logic [31:0] wd, wa;
    cyc = 1;
    nwr = 0;
    wd = '0;
    wa = '0;
    while (!done_o[d] && cyc < 30) begin
      if (mwr_o[d]) begin
        nwr++;
        wd = mwd_o[d];
        wa = madr_o[d];
      end
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, cyc, e.lat);
    chk({tag, "_nwr"}, nwr, e.nwr);
    if (e.nwr > 0) begin
      chk({tag, "_wdata"}, wd, e.wd);
      chk({tag, "_waddr"}, wa, e.wa);
    end
    chk({tag, "_rdata"}, rd_o[d], e.rd);
    chk({tag, "_mis"}, mis_o[d], e.mis);
    @(negedge clk);
    chk({tag, "_pulse"}, done_o[d], 0);
    chk({tag, "_idle"}, busy_o[d], 0);
  endtask

  task automatic access(input string tag, input int d, input logic w, input logic [1:0] sz, input logic se,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw);
    @(negedge clk);
    start(d, w, sz, se, a, wd, mw);
    @(negedge clk);
    req[d] = 1'b0;
    wait_done(d, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ndone;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; size[i] = SZ_WORD; sext[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; mrd[i] = '0; last_rd[i] = '0;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_done", done_o[0], 0);
    chk("rst_mis", mis_o[0], 0);
    chk("rst_mwr", mwr_o[0], 0);
    chk("rst_rdata", rd_o[0], 0);
    chk("rst_maddr", madr_o[0], 0);
    chk("rst_mwdata", mwd_o[0], 0);
    chk("rst_rdata3", rd_o[1], 0);
    reset = 1'b1;
    access("ldb_sx", 0, 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 32'h80FF7F01);
    access("ldb_zx", 0, 1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h0, 32'h80FF7F01);
    access("ldb_ff", 0, 1'b0, SZ_BYTE, 1'b1, 32'h102, 32'h0, 32'h80FF7F01);
    access("ldh_sx", 0, 1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0, 32'h80FF7F01);
    access("ldh_zx", 0, 1'b0, SZ_HALF, 1'b0, 32'h100, 32'h0, 32'h80FF7F01);
    access("sth", 0, 1'b1, SZ_HALF, 1'b0, 32'h202, 32'h0000ABCD, 32'h11223344);
    access("stb", 0, 1'b1, SZ_BYTE, 1'b0, 32'h301, 32'h000000AA, 32'h11223344);
    access("stw", 0, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0);
    access("ldw_mis", 0, 1'b0, SZ_WORD, 1'b0, 32'h41, 32'h0, 32'hCAFEF00D);
    access("ldh_odd", 0, 1'b0, SZ_HALF, 1'b1, 32'h203, 32'h0, 32'h9ABC1234);
    access("ld_sz3", 0, 1'b0, 2'b11, 1'b1, 32'h80, 32'h0, 32'h8765ABCD);
    access("l3_ldb", 1, 1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, 32'h0000F000);
    access("l3_stb", 1, 1'b1, SZ_BYTE, 1'b0, 32'h502, 32'h00000055, 32'hA1B2C3D4);
    access("l3_stw", 1, 1'b1, SZ_WORD, 1'b0, 32'h600, 32'h01234567, 32'h0);
    @(negedge clk);
    drive(0, 1'b1, SZ_HALF, 1'b0, 32'h202, 32'h0000ABCD, 32'h11223344);
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    chk("rst_pre_wr", mwr_o[0], 1);
    reset = 1'b0;
    #1;
    chk("rst_async_mwr", mwr_o[0], 0);
    chk("rst_async_busy", busy_o[0], 0);
    chk("rst_async_done", done_o[0], 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_o[0] || done_o[1] || mwr_o[0]) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    chk("rst_rdata_clr", rd_o[0], 0);
    chk("rst_maddr_clr", madr_o[0], 0);
    @(negedge clk);
    start(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h12345678);
    @(negedge clk);
    wait_done(1, "b2b_first");
    start(1, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'hF00D0000);
    @(negedge clk);
    chk("b2b_accept", busy_o[1], 1);
    req[1] = 1'b0;
    wait_done(1, "b2b_second");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL expose parameter MEM_LAT, default 1: memory read latency in cycles, legal range 1-4.
REQ-002 clk  in  1  the single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-low.
REQ-004 req  in  1  start-access strobe; sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load; latched with req.
REQ-006 size  in  2  access size: 00 word, 01 half, 10 byte; 11 treated as word.
REQ-007 sign_ext  in  1  for loads, 1 = sign-extend and 0 = zero-extend sub-word data; latched with req.
REQ-008 addr  in  32  byte address, as selected by the address-select mux (PC, exception vector, ALU result, result, B); latched with req.
REQ-009 wdata  in  32  store data; low byte or half is used for sub-word stores; latched with req.
REQ-010 mem_rdata  in  32  read word from memory.
REQ-011 mem_addr  out  32  word-aligned address {addr_q[31:2],2'b00}.
REQ-012 mem_wr  out  1  memory write enable.
REQ-013 mem_wdata  out  32  word to write.
REQ-014 rdata  out  32  extracted and extended load result; held until the next load completes.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 misalign  out  1  one-cycle pulse coincident with done on an alignment fault.

Function
REQ-018 FSM states SHALL be IDLE, RD, WR and DONE, and the FSM SHALL return to IDLE from DONE unconditionally.
REQ-019 A req sampled in IDLE SHALL transition as follows: load goes to RD; word store goes to WR; sub-word store goes to RD, for read-modify-write.
REQ-020 req while busy SHALL be ignored, with no queuing.
REQ-021 RD SHALL last exactly MEM_LAT cycles, and mem_rdata SHALL be captured on the final RD edge.
REQ-022 From RD, a load SHALL go to DONE and a sub-word store SHALL go to WR.
REQ-023 WR SHALL last one cycle with mem_wr=1; mem_wr SHALL be 0 in all other states.
REQ-024 In WR, mem_wdata SHALL be the captured read word with the byte or half lane selected by addr_q[1:0] replaced by wdata's low byte or half; for word stores it SHALL be wdata unchanged.
REQ-025 Data layout SHALL be little-endian: lane 0 (addr[1:0]=00) is bits 7:0, and a half at addr[1]=1 is bits 31:16.
REQ-026 For loads, rdata SHALL be updated in the DONE cycle with the extracted lane, extended per sign_ext; word loads SHALL return the full word.
REQ-027 Latency from the req edge to done: load is MEM_LAT+1 cycles; word store is 2 cycles; sub-word store is MEM_LAT+2 cycles.
REQ-028 mem_addr SHALL be driven from the latched address throughout RD and WR and held otherwise.
REQ-029 A simultaneous req and DONE SHALL leave req unaccepted, because DONE is not IDLE.

Reset
REQ-030 Asserting reset SHALL immediately force state IDLE, mem_wr=0, done=0, misalign=0, busy=0, rdata=0, mem_addr=0, mem_wdata=0 and all latched fields to 0.
REQ-031 Reset asserted mid-access (RD or WR) SHALL abort the access with no write issued after assertion and no done pulse.

Configuration
REQ-032 With ALIGN_CHECK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=00 SHALL go from IDLE directly to DONE, pulse done and misalign, perform no memory cycle, and leave rdata unchanged.
REQ-033 Without ALIGN_CHECK_EN, misalign SHALL be tied to 0 and misaligned accesses SHALL proceed: half accesses use lane addr[1]; word accesses ignore addr[1:0].

Structure
REQ-034 A shared package mem_access_pkg SHALL hold the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the FSM state constants.
REQ-035 Lane insert/extract logic SHALL be a combinational sub-module, lane_merge, instantiated once.

Verification
REQ-036 The bench SHALL cover a byte load with sign_ext=1 and MEM_LAT=1: mem word 0x80FF7F01 with addr 0x103 returns rdata=0xFFFFFF80, with done 2 cycles after req.
REQ-037 The bench SHALL cover a half store: mem word 0x11223344, addr 0x202, wdata 0x0000ABCD, producing one mem_wr with mem_wdata=0xABCD3344 at mem_addr 0x200, and done at req+3.
REQ-038 The bench SHALL cover a word store: addr 0x40, wdata 0xDEADBEEF, producing mem_wr in the cycle after req, no RD cycle, and done at req+2.
REQ-039 The bench SHALL cover an ALIGN_CHECK_EN word load at addr 0x41, producing done and misalign together at req+1, no mem_wr, and rdata unchanged.
REQ-040 The bench SHALL cover reset asserted during WR of a sub-word store, requiring mem_wr to fall asynchronously, busy=0, and no done pulse.
REQ-041 The bench SHALL cover a back-to-back req held high, requiring the second access to be accepted only in the IDLE following DONE, with a MEM_LAT=3 load done at req+4.
